// File: rtl/stage_retire_sb_pkg.sv
// Shared types for the in-order retire stage and its committed-store buffer.
package stage_retire_sb_pkg;

    localparam int XLEN       = 32;
    localparam int ARCH_IDX_W = 5;
    localparam int PRF_IDX_W  = 6;
    localparam logic [ARCH_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [3:0] {
        NO_ERROR      = 4'h0,
        HALTED_ON_WFI = 4'h2
    } EXCEPTION_CODE;

    typedef struct packed {
        logic                  retire_en;
        logic [ARCH_IDX_W-1:0] dest_reg_idx;
        logic [PRF_IDX_W-1:0]  t_idx;
        logic [PRF_IDX_W-1:0]  told_idx;
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       npc;
        logic                  take_branch;
        logic                  halt;
        logic                  wr_mem;
        logic [XLEN-1:0]       rs2_value;
        logic [2:0]            funct3;
    } ROB_IR_PACKET;

    typedef struct packed {
        logic                 retire_en;
        logic [PRF_IDX_W-1:0] told_idx;
    } IR_FL_PACKET;

    typedef struct packed {
        logic                  retire_en;
        logic [ARCH_IDX_W-1:0] dest_reg_idx;
        logic [PRF_IDX_W-1:0]  t_idx;
    } IR_MT_PACKET;

    typedef struct packed {
        logic                  wr_en;
        logic [ARCH_IDX_W-1:0] wr_idx;
        logic [XLEN-1:0]       wr_data;
        logic [XLEN-1:0]       npc;
        logic [3:0]            completed_insts;
        EXCEPTION_CODE         error_status;
    } IR_PIPELINE_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } SB_ENTRY;

    function automatic SB_ENTRY make_sb_entry(input logic [XLEN-1:0] addr,
                                              input logic [XLEN-1:0] data,
                                              input logic [2:0]      funct3);
        SB_ENTRY e;
        e.addr = addr;
        e.data = data;
        e.size = MEM_SIZE'(funct3[1:0]);
        return e;
    endfunction

endpackage

// File: rtl/stage_retire_sb_store_buffer.sv
// Circular store FIFO: up to PUSH_W ordered pushes and one pop per cycle.
module store_buffer
    import stage_retire_sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PUSH_W = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PUSH_W-1:0]            push_en,
    input  SB_ENTRY                      push_data [PUSH_W],
    input  logic                         pop,
    output SB_ENTRY                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    SB_ENTRY          mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_ptr_s [PUSH_W];
    logic [CNT_W-1:0] push_cnt_s;

    // Each pushing slot lands just past the pushes of earlier slots; pointers wrap by width.
    always_comb begin
        push_cnt_s = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            wr_ptr_s[i] = tail_r + PTR_W'(push_cnt_s);
            push_cnt_s  = push_cnt_s + CNT_W'(push_en[i]);
        end
    end

    // Pointer and occupancy update; reset drops every buffered store.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            tail_r  <= tail_r + PTR_W'(push_cnt_s);
            head_r  <= head_r + PTR_W'(pop);
            count_r <= count_r + push_cnt_s - CNT_W'(pop);
        end
    end

    // Entry storage, written only at the computed slot positions.
    always_ff @(posedge clock) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (!reset && push_en[i]) begin
                mem_r[wr_ptr_s[i]] <= push_data[i];
            end
        end
    end

    assign head  = mem_r[head_r];
    assign count = count_r;
    assign empty = (count_r == '0);

endmodule

// File: rtl/stage_retire_sb.sv
// N-wide in-order retire stage; retired stores are committed through a store buffer
// that drains to Dmem one entry per granted cycle.
module stage_retire_sb
    import stage_retire_sb_pkg::*;
#(
    parameter int RETIRE_WIDTH = 2,
    parameter int SB_DEPTH     = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  ROB_IR_PACKET                      rob_ir_packet [RETIRE_WIDTH],
    input  logic                              store_grant,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
    output IR_FL_PACKET                       ir_fl_packet [RETIRE_WIDTH],
    output IR_MT_PACKET                       ir_mt_packet [RETIRE_WIDTH],
    output IR_PIPELINE_PACKET                 pipe_packet [RETIRE_WIDTH],
    output logic                              interrupt,
    output logic [XLEN-1:0]                   branch_target,
    output BUS_COMMAND                        store2Dmem_command,
    output MEM_SIZE                           store2Dmem_size,
    output logic [XLEN-1:0]                   store2Dmem_addr,
    output logic [XLEN-1:0]                   store2Dmem_data,
    output logic                              sb_empty,
    output logic                              halted
);

    localparam int RC_W  = $clog2(RETIRE_WIDTH + 1);
    localparam int SB_CW = $clog2(SB_DEPTH + 1);

    logic [RETIRE_WIDTH-1:0] accept_s;
    logic [RETIRE_WIDTH-1:0] wr_en_s;
    logic [RETIRE_WIDTH-1:0] push_en_s;
    SB_ENTRY                 push_data_s [RETIRE_WIDTH];
    SB_ENTRY                 sb_head_s;
    logic [SB_CW-1:0]        sb_count_s;
    logic                    sb_empty_s;
    logic                    sb_pop_s;
    logic [SB_CW:0]          free_s;
    logic [SB_CW:0]          stores_s;
    logic                    stop_s;
    logic                    halt_accept_s;
    logic                    interrupt_s;
    logic [XLEN-1:0]         target_s;
    logic [RC_W-1:0]         count_s;
    logic                    halted_r;

    // In-order acceptance scan; free space excludes this cycle's pop so a store never races the bus.
    always_comb begin
        accept_s      = '0;
        stop_s        = reset | halted_r;
        stores_s      = '0;
        free_s        = (SB_CW+1)'(SB_DEPTH) - {1'b0, sb_count_s};
        halt_accept_s = 1'b0;
        interrupt_s   = 1'b0;
        target_s      = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (stop_s || !rob_ir_packet[i].retire_en) begin
                stop_s = 1'b1;
            end else if (rob_ir_packet[i].wr_mem && (stores_s + (SB_CW+1)'(1'b1) > free_s)) begin
                stop_s = 1'b1;
            end else if (rob_ir_packet[i].halt && (!sb_empty_s || (stores_s != '0))) begin
                stop_s = 1'b1;
            end else begin
                accept_s[i] = 1'b1;
                stores_s    = stores_s + (SB_CW+1)'(rob_ir_packet[i].wr_mem);
                if (rob_ir_packet[i].halt) begin
                    halt_accept_s = 1'b1;
                    stop_s        = 1'b1;
                end else if (rob_ir_packet[i].take_branch) begin
                    interrupt_s = 1'b1;
                    target_s    = rob_ir_packet[i].result;
                    stop_s      = 1'b1;
                end else begin
                    stop_s = 1'b0;
                end
            end
        end
    end

    // Per-slot free-list, map-table, trace and store-push packets.
    always_comb begin
        count_s   = '0;
        wr_en_s   = '0;
        push_en_s = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            wr_en_s[i]   = accept_s[i] && (rob_ir_packet[i].dest_reg_idx != ZERO_REG);
            push_en_s[i] = accept_s[i] && rob_ir_packet[i].wr_mem;
            push_data_s[i] = make_sb_entry(rob_ir_packet[i].result,
                                           rob_ir_packet[i].rs2_value,
                                           rob_ir_packet[i].funct3);
            count_s = count_s + RC_W'(accept_s[i]);

            ir_fl_packet[i].retire_en    = wr_en_s[i];
            ir_fl_packet[i].told_idx     = rob_ir_packet[i].told_idx;
            ir_mt_packet[i].retire_en    = wr_en_s[i];
            ir_mt_packet[i].dest_reg_idx = rob_ir_packet[i].dest_reg_idx;
            ir_mt_packet[i].t_idx        = rob_ir_packet[i].t_idx;

            pipe_packet[i].wr_en           = wr_en_s[i];
            pipe_packet[i].wr_idx          = rob_ir_packet[i].dest_reg_idx;
            pipe_packet[i].wr_data         = rob_ir_packet[i].result;
            pipe_packet[i].npc             = rob_ir_packet[i].npc;
            pipe_packet[i].completed_insts = 4'h0;
            pipe_packet[i].error_status    = NO_ERROR;
        end
        pipe_packet[0].completed_insts = 4'(count_s);
        pipe_packet[0].error_status    = halt_accept_s ? HALTED_ON_WFI : NO_ERROR;
    end

    // Halt is sticky until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else if (halt_accept_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    store_buffer #(
        .DEPTH  (SB_DEPTH),
        .PUSH_W (RETIRE_WIDTH)
    ) u_store_buffer (
        .clock     (clock),
        .reset     (reset),
        .push_en   (push_en_s),
        .push_data (push_data_s),
        .pop       (sb_pop_s),
        .head      (sb_head_s),
        .count     (sb_count_s),
        .empty     (sb_empty_s)
    );

    assign store2Dmem_command = (!reset && !sb_empty_s) ? BUS_STORE : BUS_NONE;
    assign sb_pop_s           = (store2Dmem_command == BUS_STORE) && store_grant;
    assign store2Dmem_size    = sb_head_s.size;
    assign store2Dmem_addr    = sb_head_s.addr;
    assign store2Dmem_data    = sb_head_s.data;
    assign retire_count       = count_s;
    assign interrupt          = interrupt_s;
    assign branch_target      = target_s;
    assign sb_empty           = sb_empty_s;
    assign halted             = halted_r;

endmodule

// File: tb/tb_stage_retire_sb.sv
// Randomized + directed bench for stage_retire_sb: a queue model of the store buffer
// predicts acceptance; a separate monitor checks the Dmem store stream in order.
`timescale 1ns/1ps
module tb_stage_retire_sb;
    import stage_retire_sb_pkg::*;

    localparam int W = 2;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic store_grant = 1'b0;
    ROB_IR_PACKET pkt [W];
    logic [$clog2(W+1)-1:0] retire_count;
    IR_FL_PACKET fl [W];
    IR_MT_PACKET mt [W];
    IR_PIPELINE_PACKET pipe [W];
    logic interrupt;
    logic [XLEN-1:0] branch_target;
    BUS_COMMAND cmd;
    MEM_SIZE sz;
    logic [XLEN-1:0] saddr, sdata;
    logic sb_empty, halted;

    stage_retire_sb #(.RETIRE_WIDTH(W), .SB_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .rob_ir_packet(pkt), .store_grant(store_grant),
        .retire_count(retire_count), .ir_fl_packet(fl), .ir_mt_packet(mt), .pipe_packet(pipe),
        .interrupt(interrupt), .branch_target(branch_target),
        .store2Dmem_command(cmd), .store2Dmem_size(sz), .store2Dmem_addr(saddr),
        .store2Dmem_data(sdata), .sb_empty(sb_empty), .halted(halted));

    always #5 clock = ~clock;

    SB_ENTRY exp_q [$];
    SB_ENTRY mon_e;
    bit halted_m = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    int dir_cnt = -1;
    ROB_IR_PACKET nxt_pkt [W];
    logic nxt_grant = 1'b0;
    logic nxt_reset = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 ALU, 1 store, 2 taken branch, 3 halt
    function automatic ROB_IR_PACKET mk(input bit valid, input int kind,
                                        input logic [4:0] dest, input logic [31:0] res);
        ROB_IR_PACKET p;
        p = '0;
        p.retire_en    = valid;
        p.dest_reg_idx = dest;
        p.t_idx        = 6'($urandom);
        p.told_idx     = 6'($urandom);
        p.result       = res;
        p.npc          = $urandom;
        p.wr_mem       = (kind == 1);
        p.take_branch  = (kind == 2);
        p.halt         = (kind == 3);
        p.rs2_value    = $urandom;
        p.funct3       = 3'($urandom);
        return p;
    endfunction

    function automatic ROB_IR_PACKET rand_slot(input bit valid);
        int k;
        int kind;
        logic [4:0] dest;
        k = $urandom_range(0, 99);
        kind = (k < 35) ? 1 : (k < 45) ? 2 : (k < 47) ? 3 : 0;
        dest = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        return mk(valid, kind, dest, $urandom);
    endfunction

    task automatic cycle();
        logic [W-1:0] acc, en_exp, fl_v, mt_v, wr_v;
        int n, nst, used;
        bit intr, hacc;
        logic [XLEN-1:0] tgt;
        SB_ENTRY pend [$];
        @(negedge clock);
        pkt = nxt_pkt;
        store_grant = nxt_grant;
        reset = nxt_reset;
        #1;
        for (int i = 0; i < W; i++) begin
            fl_v[i] = fl[i].retire_en;
            mt_v[i] = mt[i].retire_en;
            wr_v[i] = pipe[i].wr_en;
        end
        if (reset) begin
            chk("rst_retire_count", 64'(retire_count), 64'd0);
            chk("rst_enables", 64'({fl_v, mt_v, wr_v}), 64'd0);
            chk("rst_interrupt", 64'(interrupt), 64'd0);
            chk("rst_command", 64'(cmd), 64'(BUS_NONE));
        end else begin
            acc = '0; n = 0; nst = 0; intr = 1'b0; hacc = 1'b0; tgt = '0;
            used = exp_q.size();
            if (!halted_m) begin
                for (int i = 0; i < W; i++) begin
                    if (!pkt[i].retire_en) break;
                    if (pkt[i].wr_mem && (nst + 1 > D - used)) break;
                    if (pkt[i].halt && (used != 0 || nst != 0)) break;
                    acc[i] = 1'b1;
                    n++;
                    if (pkt[i].wr_mem) begin
                        nst++;
                        pend.push_back(make_sb_entry(pkt[i].result, pkt[i].rs2_value, pkt[i].funct3));
                    end
                    if (pkt[i].halt) begin hacc = 1'b1; break; end
                    if (pkt[i].take_branch) begin intr = 1'b1; tgt = pkt[i].result; break; end
                end
            end
            for (int i = 0; i < W; i++) en_exp[i] = acc[i] && (pkt[i].dest_reg_idx != 5'd0);
            chk("retire_count", 64'(retire_count), 64'(n));
            chk("fl_retire_en", 64'(fl_v), 64'(en_exp));
            chk("mt_retire_en", 64'(mt_v), 64'(en_exp));
            chk("pipe_wr_en", 64'(wr_v), 64'(en_exp));
            chk("completed_insts", 64'(pipe[0].completed_insts), 64'(n));
            chk("error_status", 64'(pipe[0].error_status), hacc ? 64'(HALTED_ON_WFI) : 64'(NO_ERROR));
            chk("interrupt", 64'(interrupt), 64'(intr));
            if (intr) chk("branch_target", 64'(branch_target), 64'(tgt));
            chk("sb_empty", 64'(sb_empty), 64'(used == 0));
            chk("halted", 64'(halted), 64'(halted_m));
            for (int i = 0; i < W; i++) begin
                if (acc[i]) begin
                    chk("wr_data", 64'(pipe[i].wr_data), 64'(pkt[i].result));
                    chk("npc", 64'(pipe[i].npc), 64'(pkt[i].npc));
                    chk("told_idx", 64'(fl[i].told_idx), 64'(pkt[i].told_idx));
                    chk("mt_t_idx", 64'(mt[i].t_idx), 64'(pkt[i].t_idx));
                end
            end
            if (dir_cnt >= 0) chk("directed_count", 64'(retire_count), 64'(dir_cnt));
        end
        @(posedge clock);
        #1;
        if (reset) begin
            exp_q.delete();
            halted_m = 1'b0;
        end else begin
            foreach (pend[k]) exp_q.push_back(pend[k]);
            if (hacc) halted_m = 1'b1;
        end
        dir_cnt = -1;
    endtask

    task automatic set2(input ROB_IR_PACKET a, input ROB_IR_PACKET b, input logic g, input int dc);
        nxt_pkt[0] = a;
        nxt_pkt[1] = b;
        nxt_grant = g;
        nxt_reset = 1'b0;
        dir_cnt = dc;
        cycle();
    endtask

    task automatic do_reset();
        nxt_pkt[0] = mk(1'b1, 0, 5'd3, $urandom);
        nxt_pkt[1] = mk(1'b1, 1, 5'd0, $urandom);
        nxt_grant = 1'b1;
        nxt_reset = 1'b1;
        cycle();
    endtask

    // Store-stream monitor: compares the Dmem port against the expected commit order.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (reset == 1'b0) begin
                chk("store_command", 64'(cmd), (exp_q.size() != 0) ? 64'(BUS_STORE) : 64'(BUS_NONE));
                if (exp_q.size() != 0 && store_grant) begin
                    mon_e = exp_q.pop_front();
                    chk("store_addr", 64'(saddr), 64'(mon_e.addr));
                    chk("store_data", 64'(sdata), 64'(mon_e.data));
                    chk("store_size", 64'(sz), 64'(mon_e.size));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ROB_IR_PACKET idle;
        idle = mk(1'b0, 0, 5'd0, 32'd0);
        do_reset();
        do_reset();
        set2(idle, idle, 1'b0, 0);
        // two ALU ops, second writes x0
        set2(mk(1'b1, 0, 5'd5, $urandom), mk(1'b1, 0, 5'd0, $urandom), 1'b0, 2);
        // fill to 3, then {store, store} fits only one
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b0, 2);
        set2(mk(1'b1, 1, 5'd0, $urandom), idle, 1'b0, 1);
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b0, 1);
        set2(idle, idle, 1'b0, 0);
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 0, 5'd7, $urandom), 1'b0, 0);
        set2(mk(1'b1, 0, 5'd8, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b0, 1);
        // full with pop: no same-cycle credit, then push/pop across the wrap
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b1, 0);
        for (int k = 0; k < 3; k++)
            set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b1, 1);
        for (int k = 0; k < 4; k++) set2(idle, idle, 1'b1, 0);
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b0, 2);
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b1, 2);
        for (int k = 0; k < 4; k++) set2(idle, idle, 1'b1, 0);
        // taken branch cuts the group
        set2(mk(1'b1, 2, 5'd1, 32'h0000_0100), mk(1'b1, 0, 5'd9, $urandom), 1'b0, 1);
        // halt waits behind one buffered store
        set2(mk(1'b1, 1, 5'd0, $urandom), idle, 1'b0, 1);
        set2(mk(1'b1, 3, 5'd0, $urandom), idle, 1'b0, 0);
        set2(mk(1'b1, 3, 5'd0, $urandom), idle, 1'b0, 0);
        set2(mk(1'b1, 3, 5'd0, $urandom), idle, 1'b1, 0);
        set2(mk(1'b1, 3, 5'd0, $urandom), idle, 1'b0, 1);
        set2(mk(1'b1, 0, 5'd4, $urandom), idle, 1'b0, 0);
        do_reset();
        // reset mid-drain discards buffered stores
        set2(mk(1'b1, 1, 5'd0, $urandom), mk(1'b1, 1, 5'd0, $urandom), 1'b0, 2);
        set2(mk(1'b1, 1, 5'd0, $urandom), idle, 1'b0, 1);
        do_reset();
        set2(idle, idle, 1'b1, 0);
        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            int nv;
            nv = $urandom_range(0, W);
            for (int i = 0; i < W; i++) nxt_pkt[i] = rand_slot(i < nv);
            nxt_grant = 1'($urandom_range(0, 1));
            nxt_reset = halted_m || ($urandom_range(0, 99) == 0);
            dir_cnt = -1;
            cycle();
        end
        for (int k = 0; k < 6; k++) set2(idle, idle, 1'b1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
